// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit A + B + Ci, DIGIT bits per clock, LSB first, start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add a Sub input (A - B using two's complement of B).

module serial_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             c_i,
  output logic [DIGIT-1:0] s_o,
  output logic             c_msb_o,
  output logic             c_o
);
  logic [DIGIT:0] c;
  assign c[0] = c_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  // Carry into the top bit of the slice; on the last digit this is the carry into the word MSB.
  assign c_msb_o = c[DIGIT-1];
  assign c_o     = c[DIGIT];
endmodule

module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co,
  output logic             Ovf
);
  if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
    $error("serial_adder: illegal WIDTH/DIGIT combination");
  end

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d, co_q, co_d, ovf_q, ovf_d;

  logic             sub_in;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = Sub;
`else
  assign sub_in = 1'b0;
`endif

  logic [DIGIT-1:0]       dsum;
  logic                   dcm, dco;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_nx;
  logic                   accept, last;

  serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .c_i     (cy_q),
    .s_o     (dsum),
    .c_msb_o (dcm),
    .c_o     (dco)
  );

  // New digit enters from the MSB side so the LSB digit ends up at the bottom after NDIG shifts.
  assign res_cat = {dsum, res_q};
  assign res_nx  = res_cat[WIDTH+DIGIT-1:DIGIT];
  assign accept  = start && (state_q != RUN);
  assign last    = (cnt_q == CW'(NDIG - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    s_d     = s_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      RUN: begin
        res_d = res_nx;
        cy_d  = dco;
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          s_d     = res_nx;
          co_d    = dco;
          ovf_d   = dcm ^ dco;
          state_d = DONE;
        end
      end
      default: begin
        if (accept) begin
          a_d     = A;
          b_d     = sub_in ? ~B : B;
          cy_d    = sub_in | Ci;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Co   = co_q;
  assign Ovf  = ovf_q;
endmodule
